// File: rtl/clkswitch_div.sv
// clkswitch_div: CPU clock generator. clkout is either an even division of
// hsclk_in (HS mode) or a synchronised copy of lsclk_in (LS mode). Mode
// changes park clkout at STOP_LEVEL so no half-period is ever shortened.
// Everything runs on the rising edge of hsclk_in.
module clkswitch_div #(
    parameter int   DIVW        = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic STOP_LEVEL  = 1'b1,
    parameter int   PARK_CYCLES = 2
) (
    input  logic            hsclk_in,
    input  logic            rst,
    input  logic            lsclk_in,
    input  logic            hsclk_sel,
    input  logic [DIVW-1:0] div_sel,
    output logic            clkout,
    output logic            hs_active
);

    // Park counter only needs to reach PARK_CYCLES-1; keep at least one bit.
    localparam int PW = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
    localparam logic [PW-1:0] PARK_LAST = PW'(PARK_CYCLES - 1);

    typedef enum logic [1:0] {
        LS_RUN  = 2'd0,
        WAIT_HS = 2'd1,
        HS_RUN  = 2'd2,
        WAIT_LS = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ls_d;
    logic [DIVW-1:0]        r_cnt;
    logic [DIVW-1:0]        r_div_q;
    logic [PW-1:0]          r_park;
    logic                   r_clkout;
    logic                   r_hs_active;
    logic                   w_ls_s;

    assign w_ls_s    = r_sync[SYNC_STAGES-1];
    assign clkout    = r_clkout;
    assign hs_active = r_hs_active;

    // lsclk_in is asynchronous: shift it through the synchroniser chain and
    // keep one extra delayed copy for edge detection in WAIT_LS.
    always_ff @(posedge hsclk_in or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_ls_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], lsclk_in};
            r_ls_d <= w_ls_s;
        end
    end

    // Mode FSM with registered clkout/hs_active; hs_active tracks the next state.
    always_ff @(posedge hsclk_in or posedge rst) begin
        if (rst) begin
            r_state     <= LS_RUN;
            r_clkout    <= STOP_LEVEL;
            r_hs_active <= 1'b0;
            r_cnt       <= '0;
            r_div_q     <= '0;
            r_park      <= '0;
        end else begin
            case (r_state)
                LS_RUN: begin
                    r_hs_active <= 1'b0;
                    // Only leave once both the output and the source sit at the
                    // stop level, so the current LS pulse is never cut short.
                    if (hsclk_sel && (r_clkout == STOP_LEVEL) && (w_ls_s == STOP_LEVEL)) begin
                        r_state <= WAIT_HS;
                        r_park  <= '0;
                    end else begin
                        r_clkout <= w_ls_s;
                    end
                end
                WAIT_HS: begin
                    r_clkout <= STOP_LEVEL;
                    if (r_park == PARK_LAST) begin
                        r_state     <= HS_RUN;
                        r_park      <= '0;
                        r_cnt       <= '0;
                        r_div_q     <= div_sel;
                        r_hs_active <= 1'b1;
                    end else begin
                        r_park      <= r_park + 1'b1;
                        r_hs_active <= 1'b0;
                    end
                end
                HS_RUN: begin
                    // Drop out only from the stop half; a request arriving in the
                    // other half waits for that half to finish normally.
                    if (!hsclk_sel && (r_clkout == STOP_LEVEL)) begin
                        r_state     <= WAIT_LS;
                        r_cnt       <= '0;
                        r_hs_active <= 1'b0;
                    end else begin
                        r_hs_active <= 1'b1;
                        if (r_cnt == r_div_q) begin
                            r_cnt    <= '0;
                            r_clkout <= ~r_clkout;
                            // Ratio is latched once per period so both halves match.
                            if (r_clkout == STOP_LEVEL)
                                r_div_q <= div_sel;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                WAIT_LS: begin
                    r_clkout    <= STOP_LEVEL;
                    r_hs_active <= 1'b0;
                    // Resume on the synchronised edge into the stop level so the
                    // first following pulse is a full LS half-period.
                    if ((w_ls_s == STOP_LEVEL) && (r_ls_d != STOP_LEVEL))
                        r_state <= LS_RUN;
                end
                default: begin
                    r_state     <= LS_RUN;
                    r_clkout    <= STOP_LEVEL;
                    r_hs_active <= 1'b0;
                end
            endcase
        end
    end

    // The divider counter never runs past the latched ratio.
    a_cnt_bound: assert property (@(posedge hsclk_in) disable iff (rst)
        (r_state == HS_RUN) |-> (r_cnt <= r_div_q));

    // While parked in either wait state the output sits at the stop level.
    a_parked: assert property (@(posedge hsclk_in) disable iff (rst)
        ((r_state == WAIT_HS) || (r_state == WAIT_LS)) |-> (r_clkout == STOP_LEVEL));

endmodule

// File: tb/tb_clkswitch_div.sv
// tb_clkswitch_div: directed timeline for clkswitch_div with default
// parameters. The stimulus process queues the expected clkout/hs_active for
// each fast cycle it drives; the monitor pops and compares on falling edges.
module tb_clkswitch_div;

    logic       hsclk_in;
    logic       rst;
    logic       lsclk_in;
    logic       hsclk_sel;
    logic [3:0] div_sel;
    logic       clkout;
    logic       hs_active;

    clkswitch_div #(
        .DIVW(4), .SYNC_STAGES(2), .STOP_LEVEL(1'b1), .PARK_CYCLES(2)
    ) dut (
        .hsclk_in (hsclk_in),
        .rst      (rst),
        .lsclk_in (lsclk_in),
        .hsclk_sel(hsclk_sel),
        .div_sel  (div_sel),
        .clkout   (clkout),
        .hs_active(hs_active)
    );

    typedef struct {
        int   cyc;
        logic clk;
        logic hs;
        int   tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   tag    = 0;
    int   rel_t  = 0;

    initial hsclk_in = 1'b0;
    always #5 hsclk_in = ~hsclk_in;

    // cyc = number of rising edges seen so far.
    always @(posedge hsclk_in) cyc <= cyc + 1;

    function automatic string tag_name(input int t);
        case (t)
            0: return "reset";
            1: return "ls_follow";
            2: return "ls_to_hs";
            3: return "div_change";
            4: return "hs_to_ls";
            5: return "req_pulse";
            6: return "rst_wait_ls";
            7: return "rst_hs_run";
            default: return "other";
        endcase
    endfunction

    // lsclk_in value driven ahead of edge t: period 32, starts low at edge 4.
    function automatic logic lsf(input int t);
        if (t < 4) return 1'b0;
        return (((t - 4) / 16) % 2) == 1;
    endfunction

    // LS mode: clkout after edge t equals lsclk_in sampled at edge t-2;
    // the two edges after reset release show the cleared synchroniser.
    function automatic logic exp_ls(input int t);
        if (t < rel_t + 2) return 1'b0;
        return lsf(t - 2);
    endfunction

    task automatic tick(input bit chk, input logic c, input logic h);
        lsclk_in = lsf(cyc + 1);
        if (chk) q.push_back('{cyc + 1, c, h, tag});
        @(posedge hsclk_in);
        #2;
    endtask

    task automatic hold_until(input int last, input logic c, input logic h);
        while (cyc < last) tick(1'b1, c, h);
    endtask

    task automatic ls_until(input int last, input logic h);
        while (cyc < last) tick(1'b1, exp_ls(cyc + 1), h);
    endtask

    // Monitor: compare every expectation due for the current cycle.
    always @(negedge hsclk_in) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (clkout !== e.clk || hs_active !== e.hs) begin
                n_err++;
                $display("FAIL %s cyc=%0d got clkout=%b hs_active=%b want clkout=%b hs_active=%b",
                         tag_name(e.tag), e.cyc, clkout, hs_active, e.clk, e.hs);
            end
        end
    end

    initial begin
        rst = 1'b1; hsclk_sel = 1'b0; div_sel = 4'd0; lsclk_in = 1'b0;

        // Reset: clkout at stop level, hs_active low.
        tag = 0;
        hold_until(3, 1'b1, 1'b0);
        rst = 1'b0; rel_t = 4;

        // LS follow for two LS periods.
        tag = 1;
        ls_until(69, 1'b0);

        // LS->HS: request while lsclk low; rise at edge 84 reaches clkout at 86,
        // WAIT_HS 87-88, HS_RUN from 89, stop half until 92, then period 8.
        tag = 2;
        hsclk_sel = 1'b1; div_sel = 4'd3;
        ls_until(86, 1'b0);
        hold_until(88, 1'b1, 1'b0);
        hold_until(92, 1'b1, 1'b1);
        hold_until(96, 1'b0, 1'b1);
        hold_until(100, 1'b1, 1'b1);
        hold_until(104, 1'b0, 1'b1);
        hold_until(108, 1'b1, 1'b1);
        hold_until(110, 1'b0, 1'b1);

        // Divider change mid-period: 4/4 completes, then 1/1, then 16/16, then 4/4.
        tag = 3;
        div_sel = 4'd0;
        hold_until(112, 1'b0, 1'b1);
        hold_until(116, 1'b1, 1'b1);
        hold_until(117, 1'b0, 1'b1);
        hold_until(118, 1'b1, 1'b1);
        hold_until(119, 1'b0, 1'b1);
        div_sel = 4'd15;
        hold_until(120, 1'b1, 1'b1);
        hold_until(136, 1'b0, 1'b1);
        hold_until(139, 1'b1, 1'b1);
        div_sel = 4'd3;
        hold_until(152, 1'b1, 1'b1);
        hold_until(156, 1'b0, 1'b1);
        hold_until(160, 1'b1, 1'b1);
        hold_until(164, 1'b0, 1'b1);
        hold_until(168, 1'b1, 1'b1);
        hold_until(169, 1'b0, 1'b1);

        // HS->LS in the low half: low completes at 172, park high from 173,
        // WAIT_LS from 174, resume after the ls_s rise at edge 182.
        tag = 4;
        hsclk_sel = 1'b0;
        hold_until(172, 1'b0, 1'b1);
        hold_until(173, 1'b1, 1'b1);
        hold_until(181, 1'b1, 1'b0);
        ls_until(219, 1'b0);

        // One-cycle request with clkout=1 and ls_s=1: full switch anyway,
        // HS_RUN for a single cycle at 222, then parked high in WAIT_LS.
        tag = 5;
        hsclk_sel = 1'b1;
        hold_until(220, 1'b1, 1'b0);
        hsclk_sel = 1'b0;
        hold_until(221, 1'b1, 1'b0);
        hold_until(222, 1'b1, 1'b1);
        hold_until(235, 1'b1, 1'b0);

        // Reset while parked in WAIT_LS: afterwards clkout follows the low ls_s.
        tag = 6;
        rst = 1'b1;
        hold_until(237, 1'b1, 1'b0);
        rst = 1'b0; rel_t = 238;
        ls_until(265, 1'b0);

        // Reset in HS_RUN while clkout is low: clkout must rise with no edge.
        tag = 7;
        hsclk_sel = 1'b1;
        ls_until(278, 1'b0);
        hold_until(280, 1'b1, 1'b0);
        hold_until(284, 1'b1, 1'b1);
        hold_until(285, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b1; hsclk_sel = 1'b0;
        q.push_back('{cyc, 1'b1, 1'b0, tag});
        hold_until(288, 1'b1, 1'b0);
        rst = 1'b0; rel_t = 289;
        ls_until(320, 1'b0);

        @(negedge hsclk_in);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending expectations want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
